pipeline_hazard_controller: RTL

Sequencing and hazard controller for the 5-stage datapath (IF/ID/EX/MEM/WB, 19-bit instructions, 12-bit PC, 8-bit data).
- Issues pipeline-register enables, flushes and bubbles.
- Handles load-use stalls, control-transfer squash, halt drain and stack-overflow fault.
- Sits beside the datapath and drives its pc/IF-ID/ID-EX update controls, replacing free-running stage updates.

---
 rtl/pipeline_hazard_controller_pkg.sv | 21 ++
 rtl/pipeline_hazard_controller_if.sv | 41 ++++
 rtl/pipeline_hazard_controller_load_use_detect.sv | 26 ++
 rtl/pipeline_hazard_controller.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_hazard_controller_pkg : shared encodings for hazard control  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pipeline_hazard_controller_pkg;

  localparam int          REG_AW      = 3;
  localparam logic [18:0] HALT_OPCODE = 19'h7FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_hazard_controller_if : datapath <-> hazard controller bundle |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface pipeline_hazard_controller_if;
  import pipeline_hazard_controller_pkg::*;

  logic              run;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              redirect;
  logic              halt_decoded;
  logic              stack_overflow;

  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              halted;
  logic              fault;
  logic [2:0]        state;

  // master = datapath side, slave = the controller
  modport master (
    output run, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
           redirect, halt_decoded, stack_overflow,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, halted, fault, state
  );

  modport slave (
    input  run, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
           redirect, halt_decoded, stack_overflow,
    output pc_en, ifid_en, ifid_flush, idex_bubble, halted, fault, state
  );

endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_use_detect : flags an ID instruction reading a load's target     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module load_use_detect
  import pipeline_hazard_controller_pkg::*;
(
  input  wire logic              i_ex_mem_read,
  input  wire logic [REG_AW-1:0] i_ex_rd,
  input  wire logic [REG_AW-1:0] i_id_rs,
  input  wire logic [REG_AW-1:0] i_id_rt,
  input  wire logic              i_id_uses_rt,
  output logic                   o_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  // Register 0 is deliberately not exempt: a load to r0 still stalls.
  assign w_rs_match = (i_ex_rd == i_id_rs);
  assign w_rt_match = i_id_uses_rt && (i_ex_rd == i_id_rt);
  assign o_hazard   = i_ex_mem_read && (w_rs_match || w_rt_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_hazard_controller : stall/flush/drain sequencing for 5-stage |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int DRAIN_DEPTH = 3,
  parameter int CNT_W       = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  pipeline_hazard_controller_if.slave bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic w_hazard;
  logic w_pc_en;
  logic w_ifid_en;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_halted;
  logic w_fault;

  load_use_detect u_load_use_detect (
    .i_ex_mem_read (bus.ex_mem_read),
    .i_ex_rd       (bus.ex_rd),
    .i_id_rs       (bus.id_rs),
    .i_id_rt       (bus.id_rt),
    .i_id_uses_rt  (bus.id_uses_rt),
    .o_hazard      (w_hazard)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pc_en       = 1'b0;
    w_ifid_en     = 1'b0;
    w_ifid_flush  = 1'b1;
    w_idex_bubble = 1'b1;
    w_halted      = 1'b0;
    w_fault       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.run) w_state_nxt = ST_RUN;
      end

      ST_RUN: begin
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        if (bus.stack_overflow) begin
          w_pc_en       = 1'b0;
          w_ifid_en     = 1'b0;
          w_idex_bubble = 1'b1;
          w_state_nxt   = ST_FAULT;
        end else if (bus.redirect) begin
          // Redirect outranks halt and load-use: both sit in the squashed shadow.
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
          w_cnt_nxt     = CNT_W'(FLUSH_DEPTH - 1);
          w_state_nxt   = (FLUSH_DEPTH == 1) ? ST_RUN : ST_FLUSH;
        end else if (bus.halt_decoded) begin
          w_pc_en       = 1'b0;
          w_ifid_en     = 1'b0;
          w_idex_bubble = 1'b1;
          w_cnt_nxt     = CNT_W'(DRAIN_DEPTH - 1);
          w_state_nxt   = ST_DRAIN;
        end else if (w_hazard) begin
          w_pc_en       = 1'b0;
          w_ifid_en     = 1'b0;
          w_idex_bubble = 1'b1;
        end
      end

      ST_FLUSH: begin
        w_pc_en   = 1'b1;
        w_ifid_en = 1'b1;
        if (bus.stack_overflow) begin
          w_state_nxt = ST_FAULT;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_DRAIN: begin
        w_ifid_flush = 1'b0;
        if (bus.stack_overflow) begin
          w_state_nxt = ST_FAULT;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_HALTED: begin
        w_ifid_flush = 1'b0;
        w_halted     = 1'b1;
        if (bus.run) w_state_nxt = ST_RUN;
      end

      ST_FAULT: begin
        w_ifid_flush = 1'b0;
        w_fault      = 1'b1;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.pc_en       = w_pc_en;
  assign bus.ifid_en     = w_ifid_en;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_bubble = w_idex_bubble;
  assign bus.halted      = w_halted;
  assign bus.fault       = w_fault;
  assign bus.state       = r_state;

endmodule
`default_nettype wire
